// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and frame-buffer geometry shared by the display reader.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned PIX_W     = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Free-running VGA pixel/line counters with undelayed sync and active-area flags.
module vga_sync_counter #(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE
) (
  input  logic                             pclk,
  input  logic                             reset,
  output logic [vga_timing_pkg::CNT_W-1:0] h_cnt,
  output logic [vga_timing_pkg::CNT_W-1:0] v_cnt,
  output logic                             h_sync_c,
  output logic                             v_sync_c,
  output logic                             active_c
);
  import vga_timing_pkg::*;

  localparam int unsigned H_SYNC_START = vga_timing_pkg::H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = vga_timing_pkg::V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Syncs are active low inside their windows; active area is the visible rectangle.
  always_comb begin
    h_sync_c = !((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_END)));
    v_sync_c = !((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_END)));
    active_c = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Reads the 320x240 RGB565 frame buffer with 2x2 upscale and drives 640x480 VGA pins as RGB444.
module vga_frame_reader #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned V_VISIBLE  = vga_timing_pkg::V_VISIBLE
) (
  input  logic        pclk,
  input  logic        reset,
  output logic        oe,
  output logic [16:0] rAddr,
  input  logic [15:0] rData,
  output logic        h_sync,
  output logic        v_sync,
  output logic        de,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start
);
  import vga_timing_pkg::*;

  localparam int unsigned DEPTH = RD_LATENCY + 1;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_sync_raw;
  logic             v_sync_raw;
  logic             active;
  logic [DEPTH-1:0] hs_sr;
  logic [DEPTH-1:0] vs_sr;
  logic [DEPTH-1:0] de_sr;
  rgb565_t          pix;
  logic             unused_lsbs;

  vga_sync_counter #(
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE)
  ) u_sync_counter (
    .pclk     (pclk),
    .reset    (reset),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .h_sync_c (h_sync_raw),
    .v_sync_c (v_sync_raw),
    .active_c (active)
  );

  // Halving both counters repeats each buffer pixel over a 2x2 screen block.
  assign oe    = active && !reset;
  assign rAddr = active ? (ADDR_W'(v_cnt[CNT_W-1:1]) * ADDR_W'(FB_WIDTH) + ADDR_W'(h_cnt[CNT_W-1:1]))
                        : '0;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hs_sr <= '1;
      vs_sr <= '1;
      de_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[DEPTH-2:0], h_sync_raw};
      vs_sr <= {vs_sr[DEPTH-2:0], v_sync_raw};
      de_sr <= {de_sr[DEPTH-2:0], active};
    end
  end

  assign h_sync = hs_sr[DEPTH-1];
  assign v_sync = vs_sr[DEPTH-1];
  assign de     = de_sr[DEPTH-1];

  assign pix         = rgb565_t'(rData);
  assign unused_lsbs = ^{pix.r[0], pix.g[1:0], pix.b[0]};

  // rData lines up with the stage one short of the pins; register it there or blank to black.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (de_sr[DEPTH-2]) begin
      red   <= pix.r[4:1];
      green <= pix.g[5:2];
      blue  <= pix.b[4:1];
    end else begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) frame_start <= 1'b0;
    else       frame_start <= (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized check of vga_frame_reader at read latencies 1 and 2 against a position-based model.
module tb_vga_frame_reader;

  localparam int H_TOT  = 800;
  localparam int V_TOT  = 525;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam int FB_PIX = 320 * 240;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #20 clk = ~clk;

  logic        oe1, hs1, vs1, de1, fs1;
  logic [16:0] addr1;
  logic [3:0]  r1, g1, b1;
  logic [15:0] rd1;
  logic        oe2, hs2, vs2, de2, fs2;
  logic [16:0] addr2;
  logic [3:0]  r2, g2, b2;
  logic [15:0] rd2a, rd2b;

  vga_frame_reader #(.RD_LATENCY(1)) dut1 (
    .pclk(clk), .reset(reset), .oe(oe1), .rAddr(addr1), .rData(rd1),
    .h_sync(hs1), .v_sync(vs1), .de(de1), .red(r1), .green(g1), .blue(b1),
    .frame_start(fs1)
  );

  vga_frame_reader #(.RD_LATENCY(2)) dut2 (
    .pclk(clk), .reset(reset), .oe(oe2), .rAddr(addr2), .rData(rd2b),
    .h_sync(hs2), .v_sync(vs2), .de(de2), .red(r2), .green(g2), .blue(b2),
    .frame_start(fs2)
  );

  logic [15:0] mem [0:FB_PIX-1];

  // Frame-buffer models with 1 and 2 cycles of read latency.
  always @(posedge clk) begin
    rd1  <= mem[addr1];
    rd2a <= mem[addr2];
    rd2b <= rd2a;
  end

  logic [33:0] obs1, obs2;
  assign obs1 = {oe1, addr1, hs1, vs1, de1, r1, g1, b1, fs1};
  assign obs2 = {oe2, addr2, hs2, vs2, de2, r2, g2, b2, fs2};

  localparam logic [33:0] RST_VEC = {1'b0, 17'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0};

  int tests_run = 0;
  int tests_failed = 0;
  int lat_of [2] = '{1, 2};
  int k;
  int first_de [2];
  int fs_cnt [2];
  int hs_low [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] get_obs(input int j);
    return (j == 0) ? obs1 : obs2;
  endfunction

  // Expected pin vector k clocks after reset release, from screen position arithmetic.
  function automatic logic [33:0] model(input int kk, input int lat);
    int x, y, a, d, xd, yd;
    logic act, hs, vs, den, fs;
    logic [11:0] col;
    logic [15:0] w;
    x   = kk % H_TOT;
    y   = (kk / H_TOT) % V_TOT;
    act = (x < 640) && (y < 480);
    a   = act ? (y / 2) * 320 + x / 2 : 0;
    hs  = 1'b1;
    vs  = 1'b1;
    den = 1'b0;
    col = 12'd0;
    if (kk >= lat + 1) begin
      d   = kk - lat - 1;
      xd  = d % H_TOT;
      yd  = (d / H_TOT) % V_TOT;
      hs  = !((xd >= 656) && (xd < 752));
      vs  = !((yd >= 490) && (yd < 492));
      den = (xd < 640) && (yd < 480);
      if (den) begin
        w   = mem[(yd / 2) * 320 + xd / 2];
        col = {w[15:12], w[10:7], w[4:1]};
      end
    end
    fs = (kk >= 1) && (((kk - 1) % FRAME) == 0);
    return {act, 17'(a), hs, vs, den, col, fs};
  endfunction

  task automatic clear_stats();
    k = 0;
    for (int j = 0; j < 2; j++) begin
      first_de[j] = -1;
      fs_cnt[j]   = 0;
      hs_low[j]   = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    logic [33:0] o;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      for (int j = 0; j < 2; j++) begin
        o = get_obs(j);
        check($sformatf("pins_L%0d_k%0d", lat_of[j], k), 64'(o), 64'(model(k, lat_of[j])));
        if (first_de[j] < 0 && o[13]) first_de[j] = k;
        if (o[0]) fs_cnt[j]++;
        if (k > 1000 && k <= 1800 && !o[15]) hs_low[j]++;
      end
    end
  endtask

  task automatic round_checks(input string name);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s_de_rise_L%0d", name, lat_of[j]), 64'(first_de[j]), 64'(lat_of[j] + 1));
      check($sformatf("%s_frame_start_L%0d", name, lat_of[j]), 64'(fs_cnt[j]), 64'd1);
      check($sformatf("%s_hsync_low_L%0d", name, lat_of[j]), 64'(hs_low[j]), 64'd96);
    end
  endtask

  // Assert reset between clocks, confirm it takes effect at once and holds, release on a negedge.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    check("rst_now_L1", 64'(obs1), 64'(RST_VEC));
    check("rst_now_L2", 64'(obs2), 64'(RST_VEC));
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d_L1", i), 64'(obs1), 64'(RST_VEC));
      check($sformatf("rst_hold%0d_L2", i), 64'(obs2), 64'(RST_VEC));
    end
    reset = 1'b0;
    clear_stats();
  endtask

  initial begin
    for (int i = 0; i < FB_PIX; i++) mem[i] = 16'($urandom);
    clear_stats();
    #5;
    @(negedge clk);
    do_reset(5);
    run_cycles(3 * H_TOT + 300);
    round_checks("first");

    do_reset(3);
    run_cycles(2000);
    round_checks("midreset");

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_reset(int'($urandom_range(1, 4)));
      run_cycles(int'($urandom_range(1800, 5000)));
      round_checks($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
